// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters and rr_arbiter_4.
// "release" is a reserved word, so the owner-finished strobe is named rel.
interface rr_arbiter_4_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
);
  logic          EIN;
  logic [N-1:0]  req;
  logic          rel;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          EOUT;
  logic          timeout;

  modport master (
    output EIN, req, rel,
    input  gnt, gnt_id, gnt_valid, EOUT, timeout
  );

  modport slave (
    input  EIN, req, rel,
    output gnt, gnt_id, gnt_valid, EOUT, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int unsigned N        = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_4_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (IW != $clog2(N)) begin : g_bad_iw
    $error("rr_arbiter_4: IW must equal log2(N)");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter_4: MAX_HOLD must be at least 2");
  end

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
`endif

  // First set bit of r searching p, p+1, ... modulo N; MSB flags a hit.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] w;
    logic [IW-1:0] c;
    found = 1'b0;
    w     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = p + IW'(k);
      if (!found && r[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    return {found, w};
  endfunction

  logic          grant_end;
  logic          forced;
  logic          issue;
  logic          drop;
  logic [IW:0]   pk;
  logic [N-1:0]  cand;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    issue     = 1'b0;
    drop      = 1'b0;
    forced    = 1'b0;
    grant_end = bus.rel | ~bus.req[id_q];
    cand      = bus.req;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    forced    = (hold_q == HW'(MAX_HOLD - 1));
`endif

    case (state_q)
      IDLE: begin
        issue = bus.EIN;
      end
      GRANT: begin
        if (grant_end || forced) begin
          // Outgoing owner is masked so it cannot immediately win again.
          cand      = bus.req & ~(N'(1) << id_q);
          issue     = bus.EIN;
          drop      = 1'b1;
          timeout_d = forced & ~grant_end;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          hold_d = hold_q + HW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pk = pick(cand, ptr_q);

    if (issue && pk[IW]) begin
      state_d = GRANT;
      gnt_d   = N'(1) << pk[IW-1:0];
      id_d    = pk[IW-1:0];
      valid_d = 1'b1;
      ptr_d   = pk[IW-1:0] + IW'(1);
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end else if (drop) begin
      state_d = IDLE;
      gnt_d   = '0;
      id_d    = '0;
      valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;
  // Idle indication: enabled, nobody asking, nothing held.
  assign bus.EOUT      = bus.EIN & ~(|bus.req) & ~valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4 (timeout case follows ARB_TIMEOUT_EN).
module tb_rr_arbiter_4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cnt[4];

  exp_t  sbq[$];
  string tagq[$];

  rr_arbiter_4_if #(.N(4), .IW(2)) bus ();

  rr_arbiter_4 #(.N(4), .IW(2), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.gnt = bus.gnt;
    o.id  = bus.gnt_id;
    o.v   = bus.gnt_valid;
    o.to  = bus.timeout;
    return o;
  endfunction

  task automatic check_out();
    exp_t  e;
    exp_t  o;
    string t;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", observed());
    end else begin
      e = sbq.pop_front();
      t = tagq.pop_front();
      o = observed();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed gnt=%b id=%0d v=%b to=%b expected gnt=%b id=%0d v=%b to=%b",
               t, o.gnt, o.id, o.v, o.to, e.gnt, e.id, e.v, e.to);
      end
    end
  endtask

  // Push the state expected after the next edge, clock, then compare.
  task automatic step(input string tag, input logic [3:0] g, input logic to);
    exp_t e;
    e.gnt = g;
    e.id  = idx_of(g);
    e.v   = |g;
    e.to  = to;
    sbq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_eout(input string tag, input logic exp);
    checks++;
    assert (bus.EOUT === exp) else begin
      errors++;
      $error("FAIL %s observed EOUT=%b expected EOUT=%b", tag, bus.EOUT, exp);
    end
  endtask

  // Immediate (no clock) comparison, used around asynchronous reset.
  task automatic check_now(input string tag, input logic [3:0] g);
    exp_t e;
    e.gnt = g;
    e.id  = idx_of(g);
    e.v   = |g;
    e.to  = 1'b0;
    sbq.push_back(e);
    tagq.push_back(tag);
    check_out();
  endtask

  initial begin
    logic [3:0] g;
    bus.EIN = 1'b0;
    bus.req = 4'b0000;
    bus.rel = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 4'b0000);
    check_eout("reset_eout", 1'b0);
    rst = 1'b0;

    // Basic grant then handover with no bubble.
    bus.EIN = 1'b1;
    bus.req = 4'b0101;
    step("first_grant", 4'b0001, 1'b0);
    bus.rel = 1'b1;
    step("handover_no_bubble", 4'b0100, 1'b0);
    bus.rel = 1'b0;
    bus.req = 4'b0000;
    step("drop_to_idle", 4'b0000, 1'b0);

    // Fairness from a fresh pointer.
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 4'b1111;
    step("fair_first", 4'b0001, 1'b0);
    cnt[0]++;
    g = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.rel = 1'b0;
      step("fair_hold", g, 1'b0);
      step("fair_hold", g, 1'b0);
      bus.rel = 1'b1;
      g = {g[2:0], g[3]};
      step("fair_rotate", g, 1'b0);
      if (k < 3) cnt[idx_of(g)]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      assert (cnt[i] === 1) else begin
        errors++;
        $error("FAIL fair_count[%0d] observed=%0d expected=1", i, cnt[i]);
      end
    end
    bus.rel = 1'b0;
    bus.req = 4'b0000;
    step("fair_end", 4'b0000, 1'b0);

    // Sole owner releasing while still requesting.
    bus.req = 4'b0010;
    step("sole_grant", 4'b0010, 1'b0);
    bus.rel = 1'b1;
    step("sole_bubble", 4'b0000, 1'b0);
    bus.rel = 1'b0;
    step("sole_regrant", 4'b0010, 1'b0);
    bus.req = 4'b0000;
    step("sole_end", 4'b0000, 1'b0);

    // Enable low blocks new grants; idle indication.
    bus.EIN = 1'b0;
    bus.req = 4'b1000;
    step("ein_low_block", 4'b0000, 1'b0);
    check_eout("ein_low_eout", 1'b0);
    bus.EIN = 1'b1;
    bus.req = 4'b0000;
    #1;
    check_eout("idle_eout", 1'b1);

    // Enable falling during a grant keeps it until release.
    bus.req = 4'b1000;
    step("ein_grant", 4'b1000, 1'b0);
    check_eout("busy_eout", 1'b0);
    bus.EIN = 1'b0;
    bus.req = 4'b1001;
    step("ein_fall_hold", 4'b1000, 1'b0);
    bus.rel = 1'b1;
    step("ein_fall_idle", 4'b0000, 1'b0);

    // Release while idle is ignored.
    bus.EIN = 1'b1;
    bus.req = 4'b0000;
    step("release_idle", 4'b0000, 1'b0);
    bus.rel = 1'b0;

    // Asynchronous reset mid-grant.
    bus.req = 4'b0100;
    step("pre_reset_grant", 4'b0100, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_now("async_reset_clear", 4'b0000);
    #2 rst = 1'b0;
    step("post_reset_grant", 4'b0100, 1'b0);
    bus.req = 4'b0000;
    step("post_reset_idle", 4'b0000, 1'b0);
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 4'b1100;
    step("reset_ptr_zero", 4'b0100, 1'b0);
    bus.req = 4'b0000;
    step("reset_ptr_idle", 4'b0000, 1'b0);

    // Grant hold limit.
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 4'b0011;
    step("hold_grant", 4'b0001, 1'b0);
`ifdef ARB_TIMEOUT_EN
    repeat (3) step("hold_count", 4'b0001, 1'b0);
    step("timeout_revoke", 4'b0010, 1'b1);
    step("timeout_pulse_end", 4'b0010, 1'b0);
`else
    repeat (100) step("hold_forever", 4'b0001, 1'b0);
`endif
    bus.req = 4'b0000;
    step("hold_end", 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
